// File: rtl/edge_capture_in_pio_if.sv
// Register-bus interface for the edge-capture parallel input port.
//   address    : register select (0 data, 1 reserved, 2 interruptmask, 3 edgecapture)
//   chipselect : slave select, qualifies writes only
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (slave output)
//   irq        : registered active-high interrupt request (slave output)
interface edge_capture_in_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/edge_capture_in_pio.sv
// Parallel input port with per-bit edge capture and interrupt generation.
// Each input bit gets its own lane: a synchroniser chain, a one-cycle-delayed
// copy for edge detection and a sticky capture bit cleared by writing 1s.
//
// Parameters:
//   WIDTH       : input width, 1..32
//   SYNC_STAGES : synchroniser depth, 2..4
//   EDGE_TYPE   : 0 rising, 1 falling, 2 any edge
//   IRQ_MODE    : 0 level (data & mask), 1 edge (capture & mask)
// Ports:
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset
//   in_port : asynchronous external inputs
//   bus     : register bus (slave modport)

// One input bit: synchroniser, edge detector and sticky capture flop.
module edge_capture_in_pio_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    input  logic clr,
    output logic sync_bit,
    output logic cap_bit
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   cap_q, cap_d;
    logic                   evt;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
        prev_d = sync_q[SYNC_STAGES-1];
        case (EDGE_TYPE)
            0:       evt =  sync_q[SYNC_STAGES-1] & ~prev_q;
            1:       evt = ~sync_q[SYNC_STAGES-1] &  prev_q;
            default: evt =  sync_q[SYNC_STAGES-1] ^  prev_q;
        endcase
        // A new edge beats a concurrent clear so no event is ever lost.
        cap_d = evt | (cap_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cap_q  <= cap_d;
        end
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign cap_bit  = cap_q;
endmodule

module edge_capture_in_pio #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_port,
    edge_capture_in_pio_if.slave bus
);
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] cap_w;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             wdata_unused;

    // Upper writedata bits are meaningless when WIDTH < 32.
    assign wdata_unused = ^bus.writedata;

    assign wr_en = bus.chipselect & ~bus.write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        edge_capture_in_pio_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_TYPE   (EDGE_TYPE)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .in_bit   (in_port[i]),
            .clr      (clr[i]),
            .sync_bit (sync_w[i]),
            .cap_bit  (cap_w[i])
        );
    end

    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && bus.address == 2'd3) clr    = bus.writedata[WIDTH-1:0];
        if (wr_en && bus.address == 2'd2) mask_d = bus.writedata[WIDTH-1:0];

        // Read mux is sampled every cycle; reads have no side effects.
        readdata_d = 32'd0;
        case (bus.address)
            2'd0:    readdata_d = 32'(sync_w);
            2'd2:    readdata_d = 32'(mask_q);
            2'd3:    readdata_d = 32'(cap_w);
            default: readdata_d = 32'd0;
        endcase

        if (IRQ_MODE == 1) irq_d = |(cap_w & mask_q);
        else               irq_d = |(sync_w & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q     <= '0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_edge_capture_in_pio.sv
// Bench for edge_capture_in_pio. Three instances share one bus:
//   A: WIDTH 8,  rising edge, edge irq
//   B: WIDTH 32, any edge,    edge irq
//   C: WIDTH 8,  rising edge, level irq
module tb_edge_capture_in_pio;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  ia;
    logic [31:0] ib;
    logic [7:0]  ic;

    always #5 clk = ~clk;

    edge_capture_in_pio_if bus_a ();
    edge_capture_in_pio_if bus_b ();
    edge_capture_in_pio_if bus_c ();

    assign bus_a.address = address;  assign bus_a.chipselect = chipselect;
    assign bus_a.write_n = write_n;  assign bus_a.writedata  = writedata;
    assign bus_b.address = address;  assign bus_b.chipselect = chipselect;
    assign bus_b.write_n = write_n;  assign bus_b.writedata  = writedata;
    assign bus_c.address = address;  assign bus_c.chipselect = chipselect;
    assign bus_c.write_n = write_n;  assign bus_c.writedata  = writedata;

    edge_capture_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .in_port(ia), .bus(bus_a));
    edge_capture_in_pio #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1)) dut_b (
        .clk(clk), .reset(reset), .in_port(ib), .bus(bus_b));
    edge_capture_in_pio #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) dut_c (
        .clk(clk), .reset(reset), .in_port(ic), .bus(bus_c));

    typedef struct {
        string       tag;
        int          dut;
        bit          is_irq;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [31:0] observe(input int dut, input bit is_irq);
        case (dut)
            0:       return is_irq ? {31'd0, bus_a.irq} : bus_a.readdata;
            1:       return is_irq ? {31'd0, bus_b.irq} : bus_b.readdata;
            default: return is_irq ? {31'd0, bus_c.irq} : bus_c.readdata;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop();
        exp_t        e;
        logic [31:0] o;
        e = sb.pop_front();
        o = observe(e.dut, e.is_irq);
        checks++;
        assert (o === e.exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
        end
    endtask

    // Compare an output as it stands now.
    task automatic chk(input int dut, input bit is_irq, input logic [31:0] exp, input string tag);
        exp_t e;
        e.tag = tag; e.dut = dut; e.is_irq = is_irq; e.exp = exp;
        sb.push_back(e);
        check_pop();
    endtask

    // Present an address, expect readdata one clock later.
    task automatic rd(input int dut, input logic [1:0] a, input logic [31:0] exp, input string tag);
        exp_t e;
        address = a;
        e.tag = tag; e.dut = dut; e.is_irq = 1'b0; e.exp = exp;
        sb.push_back(e);
        tick();
        check_pop();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; ia = 8'h00; ib = 32'd0; ic = 8'h00;
        ticks(2);
        chk(0, 0, 32'd0, "reset_rd_a");
        chk(0, 1, 32'd0, "reset_irq_a");
        chk(1, 0, 32'd0, "reset_rd_b");
        reset = 1'b0;
        ticks(2);
        rd(0, 2'd3, 32'd0, "idle_cap_a");
        rd(0, 2'd2, 32'd0, "idle_mask_a");
        ticks(5);

        // Capture latency: set visible on readdata one clock after capture.
        ia = 8'h05;
        rd(0, 2'd3, 32'd0, "lat_e1");
        rd(0, 2'd3, 32'd0, "lat_e2");
        rd(0, 2'd3, 32'd0, "lat_e3");
        rd(0, 2'd3, 32'h05, "lat_e4");

        // Edge irq via mask, then clear its only source.
        wr(2'd2, 32'h04);
        tick();
        chk(0, 1, 32'd1, "irq_set");
        rd(0, 2'd2, 32'h04, "mask_rd");
        wr(2'd3, 32'h04);
        chk(0, 1, 32'd1, "irq_hold_at_clear");
        tick();
        chk(0, 1, 32'd0, "irq_fall");
        rd(0, 2'd3, 32'h01, "cap_after_clear");

        // Writes to data/reserved addresses and reads leave state intact.
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        rd(0, 2'd3, 32'h01, "cap_after_wr01");
        rd(0, 2'd3, 32'h01, "cap_reread");
        rd(0, 2'd2, 32'h04, "mask_after_wr01");
        rd(0, 2'd1, 32'd0, "reserved_a");

        // Set wins over a concurrent clear.
        ia = 8'h04;
        ticks(4);
        wr(2'd3, 32'h01);
        rd(0, 2'd3, 32'h00, "bit0_cleared");
        ia = 8'h05;
        ticks(2);
        wr(2'd3, 32'h01);
        rd(0, 2'd3, 32'h01, "set_wins");

        // Full capture and mask, then reset with a concurrent write.
        ia = 8'h00;
        ticks(4);
        wr(2'd2, 32'hFF);
        ia = 8'hFF;
        ticks(4);
        rd(0, 2'd3, 32'hFF, "cap_ff");
        chk(0, 1, 32'd1, "irq_ff");
        reset = 1'b1; address = 2'd2; writedata = 32'h12; chipselect = 1'b1; write_n = 1'b0;
        tick();
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        chk(0, 0, 32'd0, "rst_mid_rd");
        chk(0, 1, 32'd0, "rst_mid_irq");
        rd(0, 2'd3, 32'd0, "rst_mid_cap");
        rd(0, 2'd2, 32'd0, "rst_mid_mask");
        ticks(2);
        rd(0, 2'd3, 32'hFF, "post_reset_rise");

        // Any-edge capture on a 32-bit port.
        ib = 32'h8;
        ticks(5);
        ib = 32'h0;
        rd(1, 2'd3, 32'h8, "any_rise");
        wr(2'd3, 32'h8);
        rd(1, 2'd3, 32'h0, "any_cleared");
        rd(1, 2'd3, 32'h8, "any_fall");
        ticks(3);

        // Full-width data path, no zero-extension at 32 bits.
        ib = 32'hA000_0001;
        ticks(2);
        rd(1, 2'd0, 32'hA000_0001, "w32_data");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(1, 2'd2, 32'hFFFF_FFFF, "w32_mask");
        rd(0, 2'd2, 32'h0000_00FF, "w8_mask_zext");
        rd(1, 2'd3, 32'hA000_0009, "w32_cap");
        chk(1, 1, 32'd1, "w32_irq");

        // Level irq follows synchronised data.
        wr(2'd2, 32'h80);
        ic = 8'h80;
        tick();
        chk(2, 1, 32'd0, "lvl_e1");
        tick();
        chk(2, 1, 32'd0, "lvl_e2");
        tick();
        chk(2, 1, 32'd1, "lvl_e3");
        ic = 8'h00;
        tick();
        chk(2, 1, 32'd1, "lvl_d1");
        tick();
        chk(2, 1, 32'd1, "lvl_d2");
        tick();
        chk(2, 1, 32'd0, "lvl_d3");
        ic = 8'hFF;
        ticks(3);
        rd(2, 2'd1, 32'd0, "reserved_c");
        rd(2, 2'd0, 32'hFF, "data_c");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
